// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: parity modes and FSM states.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: wraps every CLKS_PER_BIT cycles and flags the last cycle of each bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    output logic             tick_o,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             last;

    always_comb begin
        last  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o  = last;
    assign count_o = cnt_q;

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with one-word holding register, optional parity and 1 or 2 stop bits.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_W       = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_o,
    output logic              busy_o,
    output logic              tx_done_o
);

    import uart_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    uart_state_e       state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic              stop_idx_q, stop_idx_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              tick;
    logic [CNT_W-1:0]  count;
    logic              restart;
    logic              take;
    logic              load;
    logic              bit_last;
    logic              stop_last;
    logic              pre_tick;

    assign restart = (state_q == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart),
        .tick_o (tick),
        .count_o(count)
    );

    // All outputs are computed one cycle ahead so that they come straight from flops.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        par_d       = par_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load        = 1'b0;

        take      = in_valid && !hold_full_q;
        bit_last  = (bit_idx_q == 4'(DATA_W - 1));
        stop_last = (stop_idx_q == 1'(STOP_BITS - 1));
        pre_tick  = (count == CNT_W'(CLKS_PER_BIT - 2));

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (!bit_last) begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end else if (PARITY != PAR_NONE) begin
                        state_d = PAR;
                        tx_d    = par_q;
                    end else begin
                        state_d    = STOP;
                        stop_idx_d = 1'b0;
                        tx_d       = 1'b1;
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            STOP: begin
                done_d = stop_last && pre_tick;
                if (tick) begin
                    if (!stop_last) begin
                        stop_idx_d = 1'b1;
                    end else if (hold_full_q) begin
                        load    = 1'b1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // A load needs a full holding register and a capture needs an empty one, so they never collide.
        if (load) begin
            shift_d     = hold_q;
            par_d       = (^hold_q) ^ (PARITY == PAR_ODD);
            hold_full_d = 1'b0;
        end
        if (take) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = ~hold_full_q;
    assign tx_o      = tx_q;
    assign busy_o    = busy_q;
    assign tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four parameter variants sharing one clock and reset.
module tb_uart_tx_cfg;

    localparam int CLKS = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] inValid;
    logic [7:0] inData [4];
    wire  [3:0] inReady;
    wire  [3:0] txO;
    wire  [3:0] busyO;
    wire  [3:0] doneO;
    logic       readyLog [0:127];
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(CLKS), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) uDefault (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_data(inData[0]),
        .in_ready(inReady[0]), .tx_o(txO[0]), .busy_o(busyO[0]), .tx_done_o(doneO[0])
    );

    uart_tx_cfg #(.CLKS_PER_BIT(CLKS), .DATA_W(8), .PARITY(1), .STOP_BITS(1)) uEven (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_data(inData[1]),
        .in_ready(inReady[1]), .tx_o(txO[1]), .busy_o(busyO[1]), .tx_done_o(doneO[1])
    );

    uart_tx_cfg #(.CLKS_PER_BIT(CLKS), .DATA_W(8), .PARITY(2), .STOP_BITS(1)) uOdd (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .in_data(inData[2]),
        .in_ready(inReady[2]), .tx_o(txO[2]), .busy_o(busyO[2]), .tx_done_o(doneO[2])
    );

    uart_tx_cfg #(.CLKS_PER_BIT(CLKS), .DATA_W(8), .PARITY(0), .STOP_BITS(2)) uStop2 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[3]), .in_data(inData[3]),
        .in_ready(inReady[3]), .tx_o(txO[3]), .busy_o(busyO[3]), .tx_done_o(doneO[3])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Raise in_valid at a falling edge; the transfer happens on the next rising edge.
    task automatic applyStimulus(input logic [1:0] idx, input logic [7:0] word);
        @(negedge clk);
        checkOutput($sformatf("ready before send u%0d", idx), 32'(inReady[idx]), 32'd1);
        inData[idx]  = word;
        inValid[idx] = 1'b1;
    endtask

    // k=0 is the cycle after the transfer edge; k=1 is the first start-bit cycle.
    task automatic captureFrames(input logic [1:0] idx, input logic [31:0] expBits, input int frameBits,
                                 input int frames, input int dropAt, input logic [7:0] nextWord);
        int total;
        int b;
        total = frameBits * frames * CLKS;
        for (int k = 0; k <= total + 1; k++) begin
            @(negedge clk);
            readyLog[k] = inReady[idx];
            if (k == 0) inData[idx] = nextWord;
            if (k == dropAt) inValid[idx] = 1'b0;
            if (k >= 1 && k <= total) begin
                b = (k - 1) / CLKS;
                checkOutput($sformatf("tx u%0d k=%0d", idx, k), 32'(txO[idx]), 32'(expBits[b[4:0]]));
                checkOutput($sformatf("busy u%0d k=%0d", idx, k), 32'(busyO[idx]), 32'd1);
                checkOutput($sformatf("done u%0d k=%0d", idx, k), 32'(doneO[idx]),
                            32'((k % (frameBits * CLKS)) == 0));
            end else if (k == total + 1) begin
                checkOutput($sformatf("idle tx u%0d", idx), 32'(txO[idx]), 32'd1);
                checkOutput($sformatf("idle busy u%0d", idx), 32'(busyO[idx]), 32'd0);
                checkOutput($sformatf("idle done u%0d", idx), 32'(doneO[idx]), 32'd0);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        inValid = 4'b0000;
        for (int i = 0; i < 4; i++) inData[i] = 8'h00;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("reset tx u%0d", i), 32'(txO[i]), 32'd1);
            checkOutput($sformatf("reset busy u%0d", i), 32'(busyO[i]), 32'd0);
            checkOutput($sformatf("reset ready u%0d", i), 32'(inReady[i]), 32'd1);
            checkOutput($sformatf("reset done u%0d", i), 32'(doneO[i]), 32'd0);
        end
        rst_n = 1'b1;

        $display("[TB] default frame 0xA5");
        applyStimulus(2'd0, 8'hA5);
        captureFrames(2'd0, 32'({1'b1, 8'hA5, 1'b0}), 10, 1, 0, 8'h00);

        $display("[TB] even parity 0x07");
        applyStimulus(2'd1, 8'h07);
        captureFrames(2'd1, 32'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 1, 0, 8'h00);

        $display("[TB] odd parity 0x07");
        applyStimulus(2'd2, 8'h07);
        captureFrames(2'd2, 32'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 1, 0, 8'h00);

        $display("[TB] two stop bits 0xFF");
        applyStimulus(2'd3, 8'hFF);
        captureFrames(2'd3, 32'({2'b11, 8'hFF, 1'b0}), 11, 1, 0, 8'h00);

        $display("[TB] back-to-back 0x11 0x22");
        applyStimulus(2'd0, 8'h11);
        captureFrames(2'd0, 32'({1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0}), 10, 2, 2, 8'h22);
        checkOutput("b2b ready after first load", 32'(readyLog[1]), 32'd1);
        for (int k = 2; k <= 40; k++) begin
            checkOutput($sformatf("b2b ready held k=%0d", k), 32'(readyLog[k]), 32'd0);
        end
        checkOutput("b2b ready after second load", 32'(readyLog[41]), 32'd1);

        $display("[TB] reset during data bit 3");
        applyStimulus(2'd0, 8'h52);
        for (int k = 0; k <= 18; k++) begin
            @(negedge clk);
            if (k == 0) inData[0] = 8'h99;
            if (k == 3) inValid[0] = 1'b0;
        end
        checkOutput("pre-reset tx bit3", 32'(txO[0]), 32'd0);
        checkOutput("pre-reset busy", 32'(busyO[0]), 32'd1);
        checkOutput("pre-reset ready", 32'(inReady[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid-frame reset tx", 32'(txO[0]), 32'd1);
        checkOutput("mid-frame reset busy", 32'(busyO[0]), 32'd0);
        checkOutput("mid-frame reset ready", 32'(inReady[0]), 32'd1);
        checkOutput("mid-frame reset done", 32'(doneO[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput($sformatf("dropped word tx k=%0d", k), 32'(txO[0]), 32'd1);
            checkOutput($sformatf("dropped word busy k=%0d", k), 32'(busyO[0]), 32'd0);
        end
        applyStimulus(2'd0, 8'h3C);
        captureFrames(2'd0, 32'({1'b1, 8'h3C, 1'b0}), 10, 1, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, meaning clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter DATA_W, default 8, meaning data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, meaning in_data holds a word to send.
REQ-008 SHALL have port in_data, input, DATA_W, meaning the payload, LSB sent first.
REQ-009 SHALL have port in_ready, output, 1, meaning the holding register is empty.
REQ-010 SHALL have port tx_o, output, 1, meaning the serial line, idle high.
REQ-011 SHALL have port busy_o, output, 1, meaning a frame is being shifted.
REQ-012 SHALL have port tx_done_o, output, 1, meaning a one-cycle pulse at the end of each frame.

Function
REQ-013 SHALL transfer a word on a cycle where in_valid and in_ready are both high; in_data is captured into the holding register.
REQ-014 SHALL hold in_ready low while the holding register is full; words offered then are not captured.
REQ-015 SHALL use the states IDLE, START, DATA, PAR, STOP.
REQ-016 SHALL leave IDLE on the cycle after the holding register becomes full:
- the held word moves to the shift register;
- the holding register empties;
- state goes to START.
REQ-017 SHALL drive tx_o per state: 0 in START, bit[i] in DATA for i = 0..DATA_W-1, the parity bit in PAR, 1 in STOP and IDLE.
REQ-018 SHALL hold every bit for exactly CLKS_PER_BIT cycles, timed by a counter that restarts at every bit boundary with no drift.
REQ-019 SHALL compute the parity bit as XOR of the data bits for even, and its inverse for odd.
REQ-020 SHALL skip PAR when PARITY is 0.
REQ-021 SHALL stay in STOP for STOP_BITS times CLKS_PER_BIT cycles.
REQ-022 SHALL pulse tx_done_o high for one cycle, coincident with the last cycle of STOP.
REQ-023 SHALL, when the holding register is full at the end of STOP, enter START on the next cycle with no idle bit between frames; otherwise it enters IDLE.
REQ-024 SHALL allow one new word to be accepted into the holding register while a frame is shifting; back-to-back throughput equals line rate.
REQ-025 SHALL drive busy_o high in START, DATA, PAR and STOP, and low in IDLE.
REQ-026 SHALL, when a transfer coincides with the end of STOP, capture the word into the holding register and start it on the following cycle.
REQ-027 SHALL register tx_o with no combinational path from any input to tx_o.

Reset
REQ-028 SHALL, when rst_n is asserted, immediately force: state IDLE, tx_o 1, busy_o 0, tx_done_o 0, in_ready 1, holding register empty, counters 0.
REQ-029 SHALL abort any frame in progress when reset is asserted mid-frame, drop the held word, and leave the line high.
REQ-030 SHALL accept a transfer no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-031 SHALL place the parity encodings (PAR_NONE, PAR_EVEN, PAR_ODD) and the state encoding in shared package uart_pkg.
REQ-032 SHALL instantiate one sub-module, uart_baud_gen: a bit-period counter with a restart input and a one-cycle tick output.

Verification
REQ-033 SHALL test defaults with CLKS_PER_BIT=4: send 0xA5 -> tx_o sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles; tx_done_o pulses once at cycle 40.
REQ-034 SHALL test PARITY=1: send 0x07 -> parity bit 1; frame length 11 bits.
REQ-035 SHALL test PARITY=2: send 0x07 -> parity bit 0; frame length 11 bits.
REQ-036 SHALL test STOP_BITS=2: send 0xFF -> line high for 8 cycles after the data bits; frame length 40 cycles plus 4 cycles per stop bit beyond one.
REQ-037 SHALL test back-to-back sends of 0x11 and 0x22 with in_valid held high:
- the second word is accepted during the first frame;
- its start bit follows the first stop bit with no gap;
- in_ready stays low until the second word moves to the shift register.
REQ-038 SHALL test reset asserted during DATA bit 3 -> tx_o is 1 and busy_o is 0 immediately; the next word sends correctly after release.
